ex1_div_arbiter: RTL and testbench



---
 rtl/ex1_div_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ex1_div_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ex1_div_arbiter.sv
// ex1_div_arbiter: shares one iterative 32-bit restoring divider between EX1 lanes 0 and 1.
// Latency: 33 cycles from request to DONE for one lane, 65 for both (lane 0 first, then lane 1).
// Backpressure: holds EX1 through busy_stall during the calculation; results stay in DONE while ex_stall is high.
//
// Ports:
//   clk, rst              pipeline clock, asynchronous active-high reset
//   req0/req1             lane holds a DIV/MOD in EX1 (held while EX1 is stalled)
//   op0/op1               bit0: 0 quotient / 1 remainder, bit1: 1 unsigned / 0 signed
//   a0/a1, b0/b1          dividend / divisor per lane
//   flush                 kills any in-flight operation, ignores same-cycle requests
//   ex_stall              another source holds EX1; DONE results are held
//   busy_stall            stall request to EX1
//   res_valid, res_mask   both requested results ready / which lanes requested
//   res0_data, res1_data  per-lane results
module ex1_div_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] b0,
   input  logic [31:0] b1,
   input  logic        flush,
   input  logic        ex_stall,
   output logic        busy_stall,
   output logic        res_valid,
   output logic [1:0]  res_mask,
   output logic [31:0] res0_data,
   output logic [31:0] res1_data
);

   typedef enum logic [1:0] {IDLE, CALC0, CALC1, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  cnt;
   logic [1:0]  lat_op [2];
   logic [31:0] lat_a  [2];
   logic [31:0] lat_b  [2];
   logic [1:0]  pend;
   logic [31:0] rem_q;
   logic [31:0] quo_q;

   logic        accept;
   logic        lane;
   logic [1:0]  cur_op;
   logic [31:0] cur_a;
   logic [31:0] cur_b;
   logic        is_signed;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] rem_in;
   logic [31:0] quo_in;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] result;

   assign accept = (state == IDLE) && (req0 || req1) && !flush;

   // The datapath always works on the lane currently being calculated.
   assign lane      = (state == CALC1);
   assign cur_op    = lat_op[lane];
   assign cur_a     = lat_a[lane];
   assign cur_b     = lat_b[lane];
   assign is_signed = ~cur_op[1];
   assign neg_a     = is_signed & cur_a[31];
   assign neg_b     = is_signed & cur_b[31];
   assign abs_a     = neg_a ? -cur_a : cur_a;
   assign abs_b     = neg_b ? -cur_b : cur_b;

   // One restoring step per cycle. Count 0 seeds the partial remainder with zero
   // and the quotient shift register with |a|, so no separate init cycle is needed.
   assign rem_in  = (cnt == 5'd0) ? 32'd0 : rem_q;
   assign quo_in  = (cnt == 5'd0) ? abs_a : quo_q;
   assign shifted = {rem_in, quo_in[31]};
   assign diff    = shifted - {1'b0, abs_b};
   assign fits    = ~diff[32];
   assign rem_nxt = fits ? diff[31:0] : shifted[31:0];
   assign quo_nxt = {quo_in[30:0], fits};

   // Special cases override the iterative result at write time only, so latency
   // never depends on the operands.
   always_comb begin
      result = 32'd0;
      if (cur_b == 32'd0) begin
         result = cur_op[0] ? cur_a : 32'hFFFF_FFFF;
      end else if (is_signed && cur_a == 32'h8000_0000 && cur_b == 32'hFFFF_FFFF) begin
         result = cur_op[0] ? 32'd0 : 32'h8000_0000;
      end else if (cur_op[0]) begin
         result = neg_a ? -rem_nxt : rem_nxt;
      end else begin
         result = (neg_a ^ neg_b) ? -quo_nxt : quo_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy_stall = 1'b0;
      res_valid  = 1'b0;
      case (state)
         IDLE: begin
            busy_stall = req0 | req1;
            if (req0 || req1) begin
               state_nxt = req0 ? CALC0 : CALC1;
            end
         end
         CALC0: begin
            busy_stall = 1'b1;
            if (cnt == 5'd31) begin
               // Lane 0 is still marked pending here; it clears on this edge.
               state_nxt = (pend == 2'b11) ? CALC1 : DONE;
            end
         end
         CALC1: begin
            busy_stall = 1'b1;
            if (cnt == 5'd31) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            res_valid  = 1'b1;
            busy_stall = ex_stall;
            if (!ex_stall) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt  = IDLE;
         busy_stall = 1'b0;
      end
      // A request held high through reset must not leak onto the stall line.
      if (rst) begin
         busy_stall = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         pend      <= 2'b00;
         res_mask  <= 2'b00;
         res0_data <= 32'd0;
         res1_data <= 32'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            lat_op[i] <= 2'b00;
            lat_a[i]  <= 32'd0;
            lat_b[i]  <= 32'd0;
         end
      end else begin
         state <= state_nxt;
         if (flush) begin
            cnt       <= 5'd0;
            pend      <= 2'b00;
            res_mask  <= 2'b00;
            res0_data <= 32'd0;
            res1_data <= 32'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     lat_op[0] <= op0;
                     lat_op[1] <= op1;
                     lat_a[0]  <= a0;
                     lat_a[1]  <= a1;
                     lat_b[0]  <= b0;
                     lat_b[1]  <= b1;
                     pend      <= {req1, req0};
                     res_mask  <= {req1, req0};
                     cnt       <= 5'd0;
                  end
               end
               CALC0, CALC1: begin
                  // Counter wraps 31 -> 0, which also starts lane 1 cleanly.
                  cnt   <= cnt + 5'd1;
                  rem_q <= rem_nxt;
                  quo_q <= quo_nxt;
                  if (cnt == 5'd31) begin
                     pend[lane] <= 1'b0;
                     if (lane) begin
                        res1_data <= result;
                     end else begin
                        res0_data <= result;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex1_div_arbiter.sv
// tb_ex1_div_arbiter: directed and randomized checks of ex1_div_arbiter against an arithmetic reference.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ex1_div_arbiter;

   logic        clk;
   logic        rst;
   logic        req0;
   logic        req1;
   logic [1:0]  op0;
   logic [1:0]  op1;
   logic [31:0] a0;
   logic [31:0] a1;
   logic [31:0] b0;
   logic [31:0] b1;
   logic        flush;
   logic        ex_stall;
   logic        busy_stall;
   logic        res_valid;
   logic [1:0]  res_mask;
   logic [31:0] res0_data;
   logic [31:0] res1_data;

   int tests;
   int failed;

   ex1_div_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .req1       (req1),
      .op0        (op0),
      .op1        (op1),
      .a0         (a0),
      .a1         (a1),
      .b0         (b0),
      .b1         (b1),
      .flush      (flush),
      .ex_stall   (ex_stall),
      .busy_stall (busy_stall),
      .res_valid  (res_valid),
      .res_mask   (res_mask),
      .res0_data  (res0_data),
      .res1_data  (res1_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain SV arithmetic, with the two architecturally defined special cases.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (!op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return op[0] ? sa % sb : sa / sb;
      end
      return op[0] ? a % b : a / b;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one request at the current cycle start and follows it through DONE
   // (held for 'stall' extra cycles by ex_stall) into the following IDLE cycle.
   task automatic run_op(input logic [1:0] mask,
                         input logic [1:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                         input logic [1:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                         input int stall);
      int lat;
      logic [31:0] e0;
      logic [31:0] e1;
      lat = (mask == 2'b11) ? 65 : 33;
      e0  = ref_div(o0, x0, y0);
      e1  = ref_div(o1, x1, y1);
      req0 = mask[0]; req1 = mask[1];
      op0 = o0; a0 = x0; b0 = y0;
      op1 = o1; a1 = x1; b1 = y1;
      ex_stall = 1'b0;
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         check("busy_calc", busy_stall, 1);
         check("valid_calc", res_valid, 0);
         next_cycle();
         // Operands after acceptance must not matter.
         a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      end
      ex_stall = (stall > 0);
      for (int c = 0; c <= stall; c++) begin
         if (c == stall) ex_stall = 1'b0;
         @(negedge clk);
         check("valid_done", res_valid, 1);
         check("mask_done", res_mask, mask);
         if (mask[0]) check("res0", res0_data, e0);
         if (mask[1]) check("res1", res1_data, e1);
         if (c == stall) check("busy_done", busy_stall, 0);
         next_cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("valid_idle", res_valid, 0);
      check("busy_idle", busy_stall, 0);
      next_cycle();
   endtask

   initial begin
      logic [1:0]  m;
      logic [1:0]  ro0;
      logic [1:0]  ro1;
      logic [31:0] ra [4];
      tests = 0; failed = 0;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
      a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0; flush = 1'b0; ex_stall = 1'b0;
      #2;
      check("rst_busy", busy_stall, 0);
      check("rst_valid", res_valid, 0);
      check("rst_mask", res_mask, 0);
      check("rst_res0", res0_data, 0);
      check("rst_res1", res1_data, 0);
      next_cycle();
      next_cycle();
      rst = 1'b0;

      // Unsigned lane 0: 100 / 7.
      run_op(2'b01, 2'b10, 32'd100, 32'd7, 2'b00, 32'd0, 32'd1, 0);
      // Dual lane signed: -7 rem 2 and -7 / 2.
      run_op(2'b11, 2'b01, -32'd7, 32'd2, 2'b00, -32'd7, 32'd2, 0);
      // Divide by zero, quotient and remainder.
      run_op(2'b01, 2'b10, 32'd5, 32'd0, 2'b00, 32'd0, 32'd1, 0);
      run_op(2'b01, 2'b11, 32'd5, 32'd0, 2'b00, 32'd0, 32'd1, 0);
      // Signed overflow, quotient and remainder.
      run_op(2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 32'd1, 0);
      run_op(2'b01, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 32'd1, 0);
      // Lane 1 only.
      run_op(2'b10, 2'b00, 32'd0, 32'd1, 2'b10, 32'd1000, 32'd33, 0);
      // ex_stall held in cycles 33..36 with req0 still high in DONE.
      run_op(2'b01, 2'b10, 32'd1000, 32'd3, 2'b00, 32'd0, 32'd1, 4);

      // Flush in cycle 10 of a dual-lane op, new request in cycle 11.
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b10; op1 = 2'b10;
      a0 = 32'd77; b0 = 32'd5; a1 = 32'd88; b1 = 32'd9;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("valid_preflush", res_valid, 0);
         next_cycle();
      end
      flush = 1'b1;
      @(negedge clk);
      check("busy_flush", busy_stall, 0);
      check("valid_flush", res_valid, 0);
      next_cycle();
      flush = 1'b0;
      run_op(2'b01, 2'b00, -32'd100, 32'd9, 2'b00, 32'd0, 32'd1, 0);

      // Asynchronous reset in the middle of CALC1.
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b10; op1 = 2'b11;
      a0 = 32'd500; b0 = 32'd7; a1 = 32'd600; b1 = 32'd11;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         check("busy_prerst", busy_stall, 1);
         next_cycle();
      end
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy_stall, 0);
      check("arst_valid", res_valid, 0);
      check("arst_mask", res_mask, 0);
      check("arst_res0", res0_data, 0);
      check("arst_res1", res1_data, 0);
      next_cycle();
      rst = 1'b0;
      run_op(2'b10, 2'b00, 32'd0, 32'd1, 2'b01, 32'hFFFF_FF00, 32'd13, 0);

      // Randomized operations.
      for (int n = 0; n < 20; n++) begin
         m   = 2'($urandom_range(1, 3));
         ro0 = 2'($urandom_range(0, 3));
         ro1 = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 4))
               0: ra[k] = 32'd0;
               1: ra[k] = $urandom_range(1, 15);
               2: ra[k] = -($urandom_range(1, 15));
               default: ra[k] = $urandom;
            endcase
         end
         run_op(m, ro0, ra[0], ra[1], ro1, ra[2], ra[3], $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
